instr_fetch_unit: RTL and testbench

Instruction fetch stage for the multi-cycle MIPS core. Holds the program counter, fetches a 32-bit word from instruction memory over a ready/valid handshake, and presents it in an instruction register to the decode/control stage (opcode [31:26] drives the main control decoder). Once the execute stage signals completion, it computes the next PC from the control outputs Jump and Branch and the ALU zero flag.

---
 rtl/instr_fetch_unit.sv | 113 +++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage for the multi-cycle MIPS core.
// Holds the PC, fetches one word per instruction over a ready/valid
// handshake, keeps it in the instruction register until the execute stage
// reports completion, then selects the next PC (jr > jump > taken branch > pc+4).
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        branch,
  input  logic        alu_zero,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        stall,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        load_instr;
  logic        load_pc;
  logic [31:0] next_pc;
  logic [31:0] branch_offset;

  // The fetch address is the PC itself; the link/sequential value wraps mod 2^32.
  assign imem_addr     = pc;
  assign pc_plus4      = pc + 32'd4;
  assign branch_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignment so every flop samples
    // pre-edge values regardless of the order blocks are evaluated in.
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs; nothing here depends on imem_ready
  // except the transition and the load strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_nxt   = state;
    imem_req    = 1'b0;
    load_instr  = 1'b0;
    load_pc     = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH: begin
        imem_req = !stall;
        if (!stall && imem_ready) begin
          if (imem_err) begin
            state_nxt = HALT;
          end else begin
            load_instr = 1'b1;
            state_nxt  = ISSUE;
          end
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (exec_done && !stall) begin
          load_pc   = 1'b1;
          state_nxt = FETCH;
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Next-PC selection, only consumed when load_pc is asserted.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)                    next_pc = jr_target & ~32'd3;
    else if (jump)             next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && alu_zero) next_pc = pc_plus4 + branch_offset;
  end

  // PC and instruction register; reset clears any in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      instr <= 32'h0000_0000;
    end else begin
      if (load_pc)    pc    <= next_pc;
      if (load_instr) instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run,
// all compared every cycle against a transaction-level model of the stage.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        jump;
  logic        branch;
  logic        alu_zero;
  logic        jr;
  logic [31:0] jr_target;
  logic        stall;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: the architectural facts of the stage -- current PC, the held word,
  // whether that word is still awaiting execution, and whether a fault occurred.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_halted;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_err   (imem_err),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .exec_done  (exec_done),
    .jump       (jump),
    .branch     (branch),
    .alu_zero   (alu_zero),
    .jr         (jr),
    .jr_target  (jr_target),
    .stall      (stall),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_next_pc(input logic [31:0] cur, input logic [31:0] ir,
                                                input logic j, input logic b, input logic z,
                                                input logic r, input logic [31:0] t);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(ir[15:0]));
    if (r)           return {t[31:2], 2'b00};
    else if (j)      return {seq[31:28], ir[25:0], 2'b00};
    else if (b && z) return seq + 32'(off * 4);
    else             return seq;
  endfunction

  // Model update on each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc     <= RESET_PC;
      m_instr  <= 32'h0;
      m_valid  <= 1'b0;
      m_halted <= 1'b0;
    end else if (!m_halted && !stall) begin
      if (!m_valid) begin
        if (imem_ready) begin
          if (imem_err) m_halted <= 1'b1;
          else begin
            m_instr <= imem_rdata;
            m_valid <= 1'b1;
          end
        end
      end else if (exec_done) begin
        m_pc    <= model_next_pc(m_pc, m_instr, jump, branch, alu_zero, jr, jr_target);
        m_valid <= 1'b0;
      end
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc",          pc,          m_pc);
      check("imem_addr",   imem_addr,   m_pc);
      check("pc_plus4",    pc_plus4,    m_pc + 32'd4);
      check("instr",       instr,       m_instr);
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("halted",      32'(halted),      32'(m_halted));
      check("imem_req",    32'(imem_req),    32'(!m_halted && !m_valid && !stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_ready = 1'b0; imem_rdata = 32'h0; imem_err = 1'b0;
    exec_done  = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
    jr = 1'b0; jr_target = 32'h0; stall = 1'b0;
  endtask

  task automatic fetch_word(input logic [31:0] w, input int waits);
    for (int k = 0; k < waits; k++) tick();
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic execute(input logic j, input logic b, input logic z, input logic r,
                         input logic [31:0] t);
    jump = j; branch = b; alu_zero = z; jr = r; jr_target = t;
    exec_done = 1'b1;
    tick();
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk_en = 1'b1;
    check("reset pc",    pc,    32'h0);
    check("reset instr", instr, 32'h0);
    check("reset valid", 32'(instr_valid), 32'h0);
    check("reset halted", 32'(halted),     32'h0);
    rst_n = 1'b1;
    #1;
    check("first req", 32'(imem_req), 32'h1);

    // Zero-wait nop stream with exec_done and ready held high.
    exec_done = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("seq pc",    pc, 32'(4 * ((k + 1) / 2)));
      check("seq valid", 32'(instr_valid), 32'((k % 2) == 0));
    end
    clear_inputs();

    // Jump to 0x40, then beq with imm -2: taken -> 0x3C, not taken -> 0x44.
    fetch_word(32'h0800_0010, 0);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("j to 0x40", pc, 32'h0000_0040);
    fetch_word(32'h1000_FFFE, 0);
    execute(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    check("beq taken", pc, 32'h0000_003C);
    fetch_word(32'h0800_0010, 1);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    fetch_word(32'h1000_FFFE, 0);
    execute(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("beq not taken", pc, 32'h0000_0044);

    // j / jal in the 0x1000_0000 region.
    fetch_word(32'h03E0_0008, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0000);
    check("jr to region", pc, 32'h1000_0000);
    fetch_word(32'h0800_0010, 0);
    check("j pc_plus4", pc_plus4, 32'h1000_0004);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("j target", pc, 32'h1000_0040);
    fetch_word(32'h0C00_0010, 2);
    check("jal pc_plus4", pc_plus4, 32'h1000_0044);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("jal target", pc, 32'h1000_0040);

    // jr beats jump and branch; low bits cleared.
    fetch_word(32'h0000_0010, 0);
    execute(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2003);
    check("jr priority", pc, 32'h0000_2000);

    // Wait states, stalls, and wrap at the top of the address space.
    fetch_word(32'h0000_0000, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check("jr to top", pc, 32'hFFFF_FFFC);
    check("wrap pc_plus4", pc_plus4, 32'h0000_0000);
    tick();
    stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    #1;
    check("stall req", 32'(imem_req), 32'h0);
    tick();
    check("stall fetch valid", 32'(instr_valid), 32'h0);
    check("stall fetch instr", instr, 32'h0);
    clear_inputs();
    fetch_word(32'h0000_0000, 2);
    stall = 1'b1; exec_done = 1'b1; jr = 1'b1; jr_target = 32'h100;
    tick();
    check("stall issue pc",    pc, 32'hFFFF_FFFC);
    check("stall issue valid", 32'(instr_valid), 32'h1);
    clear_inputs();
    execute(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("wrap to zero", pc, 32'h0000_0000);

    // Reset in the middle of a wait drops the response arriving with it.
    fetch_word(32'h0000_0000, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0500);
    tick();
    rst_n = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1; clear_inputs();
    check("mid reset pc",    pc, RESET_PC);
    check("mid reset valid", 32'(instr_valid), 32'h0);
    check("mid reset instr", instr, 32'h0);
    tick();

    // Bus error halts until reset, whatever the inputs do.
    imem_ready = 1'b1; imem_err = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    clear_inputs();
    check("halted rises", 32'(halted), 32'h1);
    for (int k = 0; k < 20; k++) begin
      imem_ready = ($urandom & 1) != 0;
      exec_done  = ($urandom & 1) != 0;
      jr         = ($urandom & 1) != 0;
      jr_target  = $urandom;
      imem_rdata = $urandom;
      tick();
    end
    check("halt req", 32'(imem_req), 32'h0);
    check("halt sticky", 32'(halted), 32'h1);
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      rst_n      = !((i % 150 == 149) || ($urandom_range(0, 199) == 0));
      stall      = $urandom_range(0, 3) == 0;
      imem_ready = $urandom_range(0, 2) != 0;
      imem_err   = $urandom_range(0, 79) == 0;
      imem_rdata = $urandom;
      exec_done  = ($urandom & 1) != 0;
      jump       = ($urandom & 1) != 0;
      branch     = ($urandom & 1) != 0;
      alu_zero   = ($urandom & 1) != 0;
      jr         = $urandom_range(0, 3) == 0;
      jr_target  = $urandom;
      tick();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
